// File: rtl/qdec_cabac_package.sv
// Shared types and constants for the CABAC bin-decode arbitration slice.
package qdec_cabac_package;

  localparam int unsigned ARB_NUM_REQ = 4;

  // Arbiter session states.
  typedef enum logic [1:0] {
    IDLE_ARB = 2'd0,
    OWNED    = 2'd1,
    DRAIN    = 2'd2
  } t_state_arb;

endpackage

// File: rtl/qdec_rr_pick.sv
// Combinational round-robin priority picker.
// Searches req starting at last+1 and wrapping; the first set bit wins.
//   req     : request vector
//   last    : index of the previous winner
//   win     : one-hot winner (all zero when no request)
//   win_idx : index of the winner (0 when no request)
module qdec_rr_pick
  import qdec_cabac_package::*;
#(
  parameter int unsigned NUM_REQ = ARB_NUM_REQ,
  parameter int unsigned IDX_W   = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDX_W-1:0]   last,
  output logic [NUM_REQ-1:0] win,
  output logic [IDX_W-1:0]   win_idx
);

  int unsigned j;
  logic        found;

  always_comb begin
    win     = '0;
    win_idx = '0;
    found   = 1'b0;
    j       = 0;
    for (int unsigned i = 1; i <= NUM_REQ; i++) begin
      j = 32'(last) + i;
      if (j >= NUM_REQ) j = j - NUM_REQ;
      if (!found && req[j]) begin
        found   = 1'b1;
        win[j]  = 1'b1;
        win_idx = IDX_W'(j);
      end
    end
  end

endmodule

// File: rtl/qdec_bin_arb.sv
// Arbiter for the shared CABAC bin-decode engine.
// A requester wins a session by round robin and keeps the engine until it releases.
//   clk, rst_n          : clock, synchronous active-low reset
//   req / rel / gnt     : session request level, release pulse, registered one-hot grant
//   rq_ctx_addr(_vld)   : per-requester context address lanes (flattened)
//   rq_dec_run/EPMode   : per-requester decode request and bypass flag
//   rq_ruiBin(_vld)     : returned bin (broadcast) and per-requester valid
//   ctx_addr(_vld), dec_run, EPMode, dec_rdy, ruiBin(_vld) : engine side
//   sess_bin_cnt        : saturating bin count of the current/last session
//   err_sticky          : [0] non-owner dec_run, [1] owner dec_run overflow
module qdec_bin_arb
  import qdec_cabac_package::*;
#(
  parameter int unsigned NUM_REQ = ARB_NUM_REQ,
  parameter int unsigned CTX_AW  = 10,
  parameter int unsigned CNT_W   = 16
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [NUM_REQ-1:0]         req,
  input  logic [NUM_REQ-1:0]         rel,
  output logic [NUM_REQ-1:0]         gnt,
  input  logic [NUM_REQ*CTX_AW-1:0]  rq_ctx_addr,
  input  logic [NUM_REQ-1:0]         rq_ctx_addr_vld,
  input  logic [NUM_REQ-1:0]         rq_dec_run,
  input  logic [NUM_REQ-1:0]         rq_EPMode,
  output logic                       rq_ruiBin,
  output logic [NUM_REQ-1:0]         rq_ruiBin_vld,
  output logic [CTX_AW-1:0]          ctx_addr,
  output logic                       ctx_addr_vld,
  output logic                       dec_run,
  output logic                       EPMode,
  input  logic                       dec_rdy,
  input  logic                       ruiBin,
  input  logic                       ruiBin_vld,
  output logic [CNT_W-1:0]           sess_bin_cnt,
  output logic [1:0]                 err_sticky
);

  localparam int unsigned IDX_W = $clog2(NUM_REQ);

  t_state_arb         state_q, state_d;
  logic [IDX_W-1:0]   owner_q, owner_d;
  logic [IDX_W-1:0]   last_q, last_d;
  logic [NUM_REQ-1:0] gnt_q, gnt_d;
  logic               pending_q, pending_d;
  logic               outst_q, outst_d;
  logic               ep_pend_q, ep_pend_d;
  logic [CTX_AW-1:0]  ctx_addr_q, ctx_addr_d;
  logic               ctx_vld_q, ctx_vld_d;
  logic               dec_run_q, dec_run_d;
  logic               ep_q, ep_d;
  logic               bin_q, bin_d;
  logic [NUM_REQ-1:0] bin_vld_q, bin_vld_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [1:0]         err_q, err_d;

  logic [NUM_REQ-1:0] pick_win;
  logic [IDX_W-1:0]   pick_idx;

  qdec_rr_pick #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (IDX_W)
  ) u_pick (
    .req     (req),
    .last    (last_q),
    .win     (pick_win),
    .win_idx (pick_idx)
  );

  logic [CTX_AW-1:0] own_addr;
  logic owner_run, foreign_run, accept, bin_ok, issue, rel_own;

  assign own_addr    = rq_ctx_addr[32'(owner_q)*CTX_AW +: CTX_AW];
  // gnt_q is zero outside a session, so every dec_run then counts as foreign.
  assign owner_run   = |(rq_dec_run & gnt_q);
  assign foreign_run = |(rq_dec_run & ~gnt_q);
  assign accept      = owner_run && (state_q == OWNED) && !pending_q && !outst_q;
  assign bin_ok      = ruiBin_vld && outst_q;
  // A bin returning this cycle frees the engine for a back-to-back issue.
  assign issue       = (pending_q || accept) && dec_rdy && (!outst_q || bin_ok);
  assign rel_own     = |(rel & gnt_q) && (state_q == OWNED);

  always_comb begin
    state_d    = state_q;
    owner_d    = owner_q;
    last_d     = last_q;
    gnt_d      = gnt_q;
    ctx_addr_d = ctx_addr_q;
    ctx_vld_d  = ctx_vld_q;
    dec_run_d  = 1'b0;
    ep_d       = ep_q;
    ep_pend_d  = ep_pend_q;
    bin_d      = bin_q;
    bin_vld_d  = '0;
    cnt_d      = cnt_q;
    err_d      = err_q | {owner_run && !accept, foreign_run};
    pending_d  = pending_q;
    outst_d    = outst_q;

    if (accept) begin
      pending_d = 1'b1;
      ep_pend_d = rq_EPMode[owner_q];
    end
    if (bin_ok) begin
      outst_d   = 1'b0;
      bin_vld_d = gnt_q;
      bin_d     = ruiBin;
      if (cnt_q != '1) cnt_d = cnt_q + CNT_W'(1);
    end
    if (issue) begin
      pending_d = 1'b0;
      outst_d   = 1'b1;
      dec_run_d = 1'b1;
      ep_d      = pending_q ? ep_pend_q : rq_EPMode[owner_q];
    end

    unique case (state_q)
      IDLE_ARB: begin
        ctx_vld_d = 1'b0;
        if (|req) begin
          owner_d = pick_idx;
          last_d  = pick_idx;
          gnt_d   = pick_win;
          cnt_d   = '0;
          state_d = OWNED;
        end
      end
      OWNED: begin
        ctx_addr_d = own_addr;
        ctx_vld_d  = rq_ctx_addr_vld[owner_q];
        if (rel_own) begin
          if (!pending_q && !outst_q && !accept) begin
            gnt_d     = '0;
            ctx_vld_d = 1'b0;
            state_d   = IDLE_ARB;
          end else begin
            state_d = DRAIN;
          end
        end
      end
      DRAIN: begin
        ctx_addr_d = own_addr;
        ctx_vld_d  = rq_ctx_addr_vld[owner_q];
        if (!pending_q && !outst_q) begin
          gnt_d     = '0;
          ctx_vld_d = 1'b0;
          state_d   = IDLE_ARB;
        end
      end
      default: begin
        gnt_d   = '0;
        state_d = IDLE_ARB;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= IDLE_ARB;
      owner_q    <= '0;
      last_q     <= IDX_W'(NUM_REQ - 1);
      gnt_q      <= '0;
      pending_q  <= 1'b0;
      outst_q    <= 1'b0;
      ep_pend_q  <= 1'b0;
      ctx_addr_q <= '0;
      ctx_vld_q  <= 1'b0;
      dec_run_q  <= 1'b0;
      ep_q       <= 1'b0;
      bin_q      <= 1'b0;
      bin_vld_q  <= '0;
      cnt_q      <= '0;
      err_q      <= '0;
    end else begin
      state_q    <= state_d;
      owner_q    <= owner_d;
      last_q     <= last_d;
      gnt_q      <= gnt_d;
      pending_q  <= pending_d;
      outst_q    <= outst_d;
      ep_pend_q  <= ep_pend_d;
      ctx_addr_q <= ctx_addr_d;
      ctx_vld_q  <= ctx_vld_d;
      dec_run_q  <= dec_run_d;
      ep_q       <= ep_d;
      bin_q      <= bin_d;
      bin_vld_q  <= bin_vld_d;
      cnt_q      <= cnt_d;
      err_q      <= err_d;
    end
  end

  assign gnt           = gnt_q;
  assign ctx_addr      = ctx_addr_q;
  assign ctx_addr_vld  = ctx_vld_q;
  assign dec_run       = dec_run_q;
  assign EPMode        = ep_q;
  assign rq_ruiBin     = bin_q;
  assign rq_ruiBin_vld = bin_vld_q;
  assign sess_bin_cnt  = cnt_q;
  assign err_sticky    = err_q;

endmodule

// File: tb/tb_qdec_bin_arb.sv
// Directed bench for qdec_bin_arb: a vector table for single-session behaviour plus
// hand-written round-robin, saturation and mid-drain reset sequences. A second
// instance with a 4-bit counter shares all stimulus to exercise saturation.
module tb_qdec_bin_arb;

  localparam int unsigned N  = 4;
  localparam int unsigned AW = 10;

  logic            clk, rst_n;
  logic [N-1:0]    req, rel, rq_ctx_addr_vld, rq_dec_run, rq_EPMode;
  logic [N*AW-1:0] rq_ctx_addr;
  logic            dec_rdy, ruiBin, ruiBin_vld;

  logic [N-1:0]  gnt, rq_ruiBin_vld;
  logic          rq_ruiBin, ctx_addr_vld, dec_run, EPMode;
  logic [AW-1:0] ctx_addr;
  logic [15:0]   sess_bin_cnt;
  logic [1:0]    err_sticky;

  logic [N-1:0]  s_gnt, s_rq_ruiBin_vld;
  logic          s_rq_ruiBin, s_ctx_addr_vld, s_dec_run, s_EPMode;
  logic [AW-1:0] s_ctx_addr;
  logic [3:0]    s_sess_bin_cnt;
  logic [1:0]    s_err_sticky;

  int checks = 0;
  int errors = 0;

  qdec_bin_arb #(.NUM_REQ(N), .CTX_AW(AW), .CNT_W(16)) dut (
    .clk(clk), .rst_n(rst_n), .req(req), .rel(rel), .gnt(gnt),
    .rq_ctx_addr(rq_ctx_addr), .rq_ctx_addr_vld(rq_ctx_addr_vld),
    .rq_dec_run(rq_dec_run), .rq_EPMode(rq_EPMode),
    .rq_ruiBin(rq_ruiBin), .rq_ruiBin_vld(rq_ruiBin_vld),
    .ctx_addr(ctx_addr), .ctx_addr_vld(ctx_addr_vld), .dec_run(dec_run),
    .EPMode(EPMode), .dec_rdy(dec_rdy), .ruiBin(ruiBin), .ruiBin_vld(ruiBin_vld),
    .sess_bin_cnt(sess_bin_cnt), .err_sticky(err_sticky)
  );

  qdec_bin_arb #(.NUM_REQ(N), .CTX_AW(AW), .CNT_W(4)) dut_sat (
    .clk(clk), .rst_n(rst_n), .req(req), .rel(rel), .gnt(s_gnt),
    .rq_ctx_addr(rq_ctx_addr), .rq_ctx_addr_vld(rq_ctx_addr_vld),
    .rq_dec_run(rq_dec_run), .rq_EPMode(rq_EPMode),
    .rq_ruiBin(s_rq_ruiBin), .rq_ruiBin_vld(s_rq_ruiBin_vld),
    .ctx_addr(s_ctx_addr), .ctx_addr_vld(s_ctx_addr_vld), .dec_run(s_dec_run),
    .EPMode(s_EPMode), .dec_rdy(dec_rdy), .ruiBin(ruiBin), .ruiBin_vld(ruiBin_vld),
    .sess_bin_cnt(s_sess_bin_cnt), .err_sticky(s_err_sticky)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]  req, rel, run, ep;
    logic        rdy, bin, bvld;
    logic [3:0]  e_gnt;
    logic        e_run, e_ep;
    logic [3:0]  e_vld;
    logic        e_bin;
    logic [15:0] e_cnt;
    logic [1:0]  e_err;
  } vec_t;

  function automatic vec_t mk(logic [3:0] rq, logic [3:0] rl, logic [3:0] rn, logic [3:0] ep,
                              logic rdy, logic bin, logic bvld, logic [3:0] e_gnt,
                              logic e_run, logic e_ep, logic [3:0] e_vld, logic e_bin,
                              logic [15:0] e_cnt, logic [1:0] e_err);
    vec_t v;
    v.req = rq; v.rel = rl; v.run = rn; v.ep = ep;
    v.rdy = rdy; v.bin = bin; v.bvld = bvld;
    v.e_gnt = e_gnt; v.e_run = e_run; v.e_ep = e_ep; v.e_vld = e_vld;
    v.e_bin = e_bin; v.e_cnt = e_cnt; v.e_err = e_err;
    return v;
  endfunction

  function automatic logic [AW-1:0] lane_addr(int idx);
    return AW'(256 + idx * 17);
  endfunction

  function automatic int idx_of(logic [3:0] oh);
    int r = 0;
    for (int k = 0; k < 4; k++) if (oh[k]) r = k;
    return r;
  endfunction

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    req = '0; rel = '0; rq_dec_run = '0; rq_EPMode = '0;
    dec_rdy = 1'b1; ruiBin = 1'b0; ruiBin_vld = 1'b0;
  endtask

  vec_t vecs[27];

  initial begin
    logic [3:0] mask;
    vecs[0]  = mk(4'b0100, 4'b0000, 4'b0000, 4'b0000, 0, 0, 0, 4'b0100, 0, 0, 4'b0000, 0, 0, 2'b00);
    vecs[1]  = mk(4'b0100, 4'b0000, 4'b0100, 4'b0100, 1, 0, 0, 4'b0100, 1, 1, 4'b0000, 0, 0, 2'b00);
    vecs[2]  = mk(4'b0100, 4'b0000, 4'b0000, 4'b0000, 1, 1, 1, 4'b0100, 0, 0, 4'b0100, 1, 1, 2'b00);
    vecs[3]  = mk(4'b0100, 4'b0000, 4'b0100, 4'b0000, 0, 0, 0, 4'b0100, 0, 0, 4'b0000, 0, 1, 2'b00);
    vecs[4]  = mk(4'b0100, 4'b0000, 4'b0100, 4'b0000, 0, 0, 0, 4'b0100, 0, 0, 4'b0000, 0, 1, 2'b10);
    vecs[5]  = mk(4'b0100, 4'b0000, 4'b0000, 4'b0000, 0, 0, 0, 4'b0100, 0, 0, 4'b0000, 0, 1, 2'b10);
    vecs[6]  = mk(4'b0100, 4'b0000, 4'b0000, 4'b0000, 0, 0, 0, 4'b0100, 0, 0, 4'b0000, 0, 1, 2'b10);
    vecs[7]  = mk(4'b0100, 4'b0000, 4'b0000, 4'b0000, 0, 0, 0, 4'b0100, 0, 0, 4'b0000, 0, 1, 2'b10);
    vecs[8]  = mk(4'b0100, 4'b0000, 4'b0000, 4'b0000, 1, 0, 0, 4'b0100, 1, 0, 4'b0000, 0, 1, 2'b10);
    vecs[9]  = mk(4'b0100, 4'b0000, 4'b0000, 4'b0000, 1, 0, 0, 4'b0100, 0, 0, 4'b0000, 0, 1, 2'b10);
    vecs[10] = mk(4'b0100, 4'b0000, 4'b0000, 4'b0000, 1, 0, 1, 4'b0100, 0, 0, 4'b0100, 0, 2, 2'b10);
    vecs[11] = mk(4'b0100, 4'b0000, 4'b1000, 4'b0000, 1, 0, 0, 4'b0100, 0, 0, 4'b0000, 0, 2, 2'b11);
    vecs[12] = mk(4'b0100, 4'b0000, 4'b0100, 4'b0000, 1, 0, 0, 4'b0100, 1, 0, 4'b0000, 0, 2, 2'b11);
    vecs[13] = mk(4'b0100, 4'b0000, 4'b0000, 4'b0000, 1, 1, 1, 4'b0100, 0, 0, 4'b0100, 1, 3, 2'b11);
    vecs[14] = mk(4'b0100, 4'b0000, 4'b0000, 4'b0000, 1, 1, 1, 4'b0100, 0, 0, 4'b0000, 0, 3, 2'b11);
    vecs[15] = mk(4'b0110, 4'b0000, 4'b0100, 4'b0000, 1, 0, 0, 4'b0100, 1, 0, 4'b0000, 0, 3, 2'b11);
    vecs[16] = mk(4'b0010, 4'b0100, 4'b0000, 4'b0000, 1, 0, 0, 4'b0100, 0, 0, 4'b0000, 0, 3, 2'b11);
    vecs[17] = mk(4'b0010, 4'b0000, 4'b0000, 4'b0000, 1, 0, 0, 4'b0100, 0, 0, 4'b0000, 0, 3, 2'b11);
    vecs[18] = mk(4'b0010, 4'b0000, 4'b0000, 4'b0000, 1, 1, 1, 4'b0100, 0, 0, 4'b0100, 1, 4, 2'b11);
    vecs[19] = mk(4'b0010, 4'b0000, 4'b0000, 4'b0000, 1, 0, 0, 4'b0000, 0, 0, 4'b0000, 0, 4, 2'b11);
    vecs[20] = mk(4'b0010, 4'b0000, 4'b0000, 4'b0000, 1, 0, 0, 4'b0010, 0, 0, 4'b0000, 0, 0, 2'b11);
    vecs[21] = mk(4'b0000, 4'b0010, 4'b0000, 4'b0000, 1, 0, 0, 4'b0000, 0, 0, 4'b0000, 0, 0, 2'b11);
    vecs[22] = mk(4'b1000, 4'b0000, 4'b0000, 4'b0000, 1, 0, 0, 4'b1000, 0, 0, 4'b0000, 0, 0, 2'b11);
    vecs[23] = mk(4'b1000, 4'b1000, 4'b1000, 4'b1000, 0, 0, 0, 4'b1000, 0, 0, 4'b0000, 0, 0, 2'b11);
    vecs[24] = mk(4'b1000, 4'b0000, 4'b0000, 4'b0000, 1, 0, 0, 4'b1000, 1, 1, 4'b0000, 0, 0, 2'b11);
    vecs[25] = mk(4'b1000, 4'b0000, 4'b0000, 4'b0000, 1, 0, 1, 4'b1000, 0, 0, 4'b1000, 0, 1, 2'b11);
    vecs[26] = mk(4'b0000, 4'b0000, 4'b0000, 4'b0000, 1, 0, 0, 4'b0000, 0, 0, 4'b0000, 0, 1, 2'b11);

    for (int i = 0; i < int'(N); i++) rq_ctx_addr[i*AW +: AW] = lane_addr(i);
    rq_ctx_addr_vld = '1;
    idle_inputs();
    rst_n = 1'b0;
    tick();
    tick();

    check("rst_gnt", 32'(gnt), 0);
    check("rst_dec_run", 32'(dec_run), 0);
    check("rst_ctx_vld", 32'(ctx_addr_vld), 0);
    check("rst_cnt", 32'(sess_bin_cnt), 0);
    check("rst_err", 32'(err_sticky), 0);
    check("rst_bin_vld", 32'(rq_ruiBin_vld), 0);
    rst_n = 1'b1;

    // Single-session table.
    for (int i = 0; i < 27; i++) begin
      req = vecs[i].req; rel = vecs[i].rel; rq_dec_run = vecs[i].run;
      rq_EPMode = vecs[i].ep; dec_rdy = vecs[i].rdy;
      ruiBin = vecs[i].bin; ruiBin_vld = vecs[i].bvld;
      tick();
      check($sformatf("v%0d_gnt", i), 32'(gnt), 32'(vecs[i].e_gnt));
      check($sformatf("v%0d_dec_run", i), 32'(dec_run), 32'(vecs[i].e_run));
      check($sformatf("v%0d_bin_vld", i), 32'(rq_ruiBin_vld), 32'(vecs[i].e_vld));
      check($sformatf("v%0d_cnt", i), 32'(sess_bin_cnt), 32'(vecs[i].e_cnt));
      check($sformatf("v%0d_err", i), 32'(err_sticky), 32'(vecs[i].e_err));
      if (vecs[i].e_vld != 0)
        check($sformatf("v%0d_bin", i), 32'(rq_ruiBin), 32'(vecs[i].e_bin));
      if (vecs[i].e_run) begin
        check($sformatf("v%0d_ep", i), 32'(EPMode), 32'(vecs[i].e_ep));
        check($sformatf("v%0d_ctx", i), 32'(ctx_addr), 32'(lane_addr(idx_of(vecs[i].e_gnt))));
        check($sformatf("v%0d_ctx_vld", i), 32'(ctx_addr_vld), 1);
      end
    end

    // Round robin with all requesting: order 0,1,2,3,0, one idle cycle between grants.
    idle_inputs();
    req = 4'b1111;
    for (int k = 0; k < 5; k++) begin
      mask = 4'b0001 << (k % 4);
      tick();
      check($sformatf("rr%0d_gnt", k), 32'(gnt), 32'(mask));
      rq_dec_run = mask;
      tick();
      rq_dec_run = '0;
      check($sformatf("rr%0d_dec_run", k), 32'(dec_run), 1);
      ruiBin_vld = 1'b1;
      ruiBin = k[0];
      tick();
      ruiBin_vld = 1'b0;
      check($sformatf("rr%0d_bin_vld", k), 32'(rq_ruiBin_vld), 32'(mask));
      check($sformatf("rr%0d_bin", k), 32'(rq_ruiBin), 32'(k[0]));
      rel = mask;
      tick();
      rel = '0;
      check($sformatf("rr%0d_gap", k), 32'(gnt), 0);
    end

    // Long session: the 4-bit counter saturates, the 16-bit one keeps counting.
    idle_inputs();
    req = 4'b0001;
    tick();
    check("sat_gnt", 32'(gnt), 1);
    for (int n = 1; n <= 20; n++) begin
      rq_dec_run = 4'b0001;
      tick();
      rq_dec_run = '0;
      ruiBin_vld = 1'b1;
      tick();
      ruiBin_vld = 1'b0;
      check($sformatf("sat_cnt4_%0d", n), 32'(s_sess_bin_cnt), (n > 15) ? 15 : n);
    end
    check("sat_cnt16", 32'(sess_bin_cnt), 20);

    // Release with a bin in flight, then reset while draining.
    rq_dec_run = 4'b0001;
    tick();
    rq_dec_run = '0;
    rel = 4'b0001;
    tick();
    rel = '0;
    check("drain_gnt", 32'(gnt), 1);
    rst_n = 1'b0;
    ruiBin_vld = 1'b1;
    tick();
    check("mrst_gnt", 32'(gnt), 0);
    check("mrst_cnt", 32'(sess_bin_cnt), 0);
    check("mrst_err", 32'(err_sticky), 0);
    check("mrst_bin_vld", 32'(rq_ruiBin_vld), 0);
    check("mrst_ctx", 32'({ctx_addr, ctx_addr_vld, dec_run, EPMode, rq_ruiBin}), 0);
    rst_n = 1'b1;
    req = 4'b1111;
    tick();
    check("post_rst_gnt", 32'(gnt), 1);
    check("post_rst_bin_vld", 32'(rq_ruiBin_vld), 0);
    check("post_rst_cnt", 32'(sess_bin_cnt), 0);
    idle_inputs();
    tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/qdec_bin_arb.md
Name: qdec_bin_arb

Overview:
- Arbitrates the single shared CABAC bin-decode engine among NUM_REQ sub-FSM requesters, for example the CU, PU, TU and SAO controllers.
- A requester wins ownership through round-robin arbitration and keeps the engine for a whole syntax session.
- While it owns the engine, its context address, dec_run pulses and EPMode are forwarded to the engine, and returned bins are routed back to it alone.
- The block sits between the per-syntax FSMs and the arithmetic decoding engine / context memory.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- CTX_AW, 10, context address width.
- CNT_W, 16, width of the per-session bin counter.

Ports:
- clk  in  1  clock
- rst_n  in  1  reset, synchronous, active-low
- req  in  NUM_REQ  per-requester level request for a session
- rel  in  NUM_REQ  per-requester one-cycle release pulse; ends the session
- gnt  out  NUM_REQ  one-hot ownership, registered
- rq_ctx_addr  in  NUM_REQ*CTX_AW  flattened per-requester context address
- rq_ctx_addr_vld  in  NUM_REQ  per-requester context address valid
- rq_dec_run  in  NUM_REQ  per-requester one-cycle bin-decode request
- rq_EPMode  in  NUM_REQ  per-requester bypass-mode flag, sampled with rq_dec_run
- rq_ruiBin  out  1  returned bin, broadcast to all requesters
- rq_ruiBin_vld  out  NUM_REQ  bin-valid, asserted only toward the owner
- ctx_addr  out  CTX_AW  context address to the engine
- ctx_addr_vld  out  1  context address valid to the engine
- dec_run  out  1  one-cycle decode pulse to the engine
- EPMode  out  1  bypass-mode flag to the engine
- dec_rdy  in  1  engine can accept dec_run
- ruiBin  in  1  bin from the engine
- ruiBin_vld  in  1  bin valid from the engine
- sess_bin_cnt  out  CNT_W  bins returned in the current or last session; saturates at all-ones
- err_sticky  out  2  bit0 = dec_run from a non-owner; bit1 = dec_run overflow; cleared only by reset

Behaviour:
- Reset values:
  - Every output is 0.
  - State is IDLE_ARB.
  - The last-winner pointer is NUM_REQ-1, so req[0] wins first.
  - The pending and outstanding flags are 0.
- State IDLE_ARB:
  - If any req bit is 1, the winner is the first set bit searching from last+1, wrapping.
  - The winner is registered into owner and the pointer; gnt goes one-hot on the next cycle; sess_bin_cnt clears to 0; go to OWNED.
  - Grant latency is 1 cycle from req.
- State OWNED:
  - ctx_addr and ctx_addr_vld are registered copies of the owner's lanes, 1-cycle latency. Non-owner lanes are ignored.
  - An owner rq_dec_run pulse sets pending and captures EPMode.
  - The engine dec_run pulses on the cycle after pending=1 and dec_rdy=1 and outstanding=0. That cycle clears pending and sets outstanding.
  - Best case, owner rq_dec_run at t gives engine dec_run at t+1.
  - An owner rq_dec_run while pending=1 or outstanding=1 is dropped and sets err_sticky[1].
  - A rq_dec_run from a non-owner is dropped and sets err_sticky[0]. The same rule applies in IDLE_ARB and DRAIN.
  - Engine ruiBin_vld at t gives rq_ruiBin=ruiBin and rq_ruiBin_vld[owner]=1 at t+1. The same edge clears outstanding and increments sess_bin_cnt (saturating).
  - ruiBin_vld while outstanding=0 is ignored and not counted.
- Release (rel[owner]=1):
  - With pending=0 and outstanding=0: gnt drops the next cycle; go to IDLE_ARB.
  - With pending=1: the pending request is issued normally; go to DRAIN.
  - With outstanding=1 only: go to DRAIN.
  - rel from a non-owner is ignored.
- State DRAIN:
  - gnt stays asserted.
  - Remaining bins are still routed to the owner.
  - When pending=0 and outstanding=0, gnt drops and the block goes to IDLE_ARB.
- Re-arbitration:
  - The earliest new grant comes 1 cycle after returning to IDLE_ARB.
  - The same requester wins again only if no other req is set.
- Ownership is never preempted; req deassertion without rel does not end a session.
- rel and rq_dec_run from the owner in the same cycle: the request is captured and then drained.
- ruiBin_vld and a new issue in the same cycle: outstanding clears and sets again; the bin is still routed.
- Reset asserted mid-session returns the block to reset values on the next edge. Any in-flight bin is discarded.

Decomposition:
- In qdec_cabac_package:
  - enum t_state_arb {IDLE_ARB, OWNED, DRAIN}
  - constant ARB_NUM_REQ=4
- One sub-module, qdec_rr_pick: a combinational round-robin priority picker with inputs req and last and outputs a one-hot winner plus its index.

Test Plan:
- Reset, then req=4'b0100 → gnt=4'b0100 one cycle later; rq_dec_run[2] pulse with dec_rdy=1 → dec_run at +1 with the lane-2 ctx_addr; ruiBin_vld=1, ruiBin=1 → rq_ruiBin_vld=4'b0100, rq_ruiBin=1 at +1; sess_bin_cnt=1.
- req=4'b1111 held, each owner releases after 1 bin → grant order 0,1,2,3,0; one IDLE_ARB cycle between gnt changes.
- dec_rdy=0 for 5 cycles after an owner rq_dec_run → no dec_run until dec_rdy=1, then exactly one pulse; a second rq_dec_run meanwhile → dropped and err_sticky=2'b10.
- rel while a bin is outstanding → gnt held through DRAIN; bin delivered to the owner; gnt=0 the cycle after; a waiting requester is granted next.
- Non-owner rq_dec_run[3] while owner is 1 → engine dec_run stays 0; err_sticky[0]=1; owner traffic unaffected.
- 70000 bins in one session with CNT_W=16 → sess_bin_cnt saturates at 16'hFFFF; reset mid-DRAIN → all outputs 0 and next grant goes to req[0].
